edge_detector_multi: RTL

Parametrised multi-channel edge detector for asynchronous level inputs, successor to the single-bit rising/falling detector. Each channel has a synchronizer, a debounce filter, per-channel edge-mode selection and registered single-cycle pulses. Events are also recorded in sticky flags with write-1-to-clear, a summary interrupt and a saturating event counter. The block sits between raw GPIO/status pins and the control/interrupt logic.

---
 rtl/edge_detector_multi.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/edge_detector_multi.sv
// -----------------------------------------------------------------------------
// edge_detector_multi
//
// Multi-channel edge detector for asynchronous level inputs. Each channel runs
// through a synchronizer chain, an optional debounce filter and a one-cycle
// delay. The filtered level and its delayed copy are compared to produce
// registered one-cycle rising/falling pulses, gated by a per-channel mode.
// Generated pulses also set sticky flags (write-1-to-clear), drive a summary
// interrupt and advance a saturating event counter.
//
// Compile-time option:
//   EDGE_DET_FILTER_EN  defined   -> debounce filter of FILTER_LEN cycles
//                       undefined -> no filter; the filtered level follows the
//                                    sync output every cycle (FILTER_LEN unused)
//
// Parameters:
//   WIDTH        number of channels
//   SYNC_STAGES  synchronizer flops per channel
//   FILTER_LEN   cycles a new level must stay stable to be accepted
//   CNT_W        event counter width
//
// Ports:
//   clk         clock, all flops on posedge
//   rst         synchronous active-high reset
//   signal_inp  [WIDTH]     asynchronous level inputs
//   mode        [2*WIDTH]   per channel {fall_en, rise_en}
//   clr         [WIDTH]     write-1-to-clear for evt_sticky
//   cnt_clr                 clears evt_cnt
//   p_edge      [WIDTH]     one-cycle pulse on accepted rising edge
//   n_edge      [WIDTH]     one-cycle pulse on accepted falling edge
//   evt_sticky  [WIDTH]     sticky event flags
//   irq                     OR of evt_sticky
//   evt_cnt     [CNT_W]     saturating count of generated pulses
// -----------------------------------------------------------------------------
module edge_detector_multi #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   signal_inp,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic               cnt_clr,
  output logic [WIDTH-1:0]   p_edge,
  output logic [WIDTH-1:0]   n_edge,
  output logic [WIDTH-1:0]   evt_sticky,
  output logic               irq,
  output logic [CNT_W-1:0]   evt_cnt
);

  localparam int POP_W = $clog2(WIDTH + 1);
  // Extra headroom so base + popcount never overflows before saturation.
  localparam int SUM_W = CNT_W + POP_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (WIDTH < 1 || SYNC_STAGES < 1 || FILTER_LEN < 1 || CNT_W < 1) begin : g_param_check
    $error("edge_detector_multi: all parameters must be >= 1");
  end

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d_reg;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] new_p;
  logic [WIDTH-1:0] new_n;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   filt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg[0] <= signal_inp[gi];
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_reg[s] <= sync_reg[s-1];
          end
        end
      end

`ifdef EDGE_DET_FILTER_EN
      localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
      logic [FCW-1:0] fcnt_reg;

      // The counter measures how long the sync output has disagreed with the
      // accepted level; any return to agreement throws the partial count away.
      always_ff @(posedge clk) begin
        if (rst) begin
          fcnt_reg <= '0;
          filt_reg <= 1'b0;
        end else if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
          fcnt_reg <= '0;
        end else if (fcnt_reg == FCW'(FILTER_LEN - 1)) begin
          filt_reg <= sync_reg[SYNC_STAGES-1];
          fcnt_reg <= '0;
        end else begin
          fcnt_reg <= fcnt_reg + FCW'(1);
        end
      end
`else
      always_ff @(posedge clk) begin
        if (rst) begin
          filt_reg <= 1'b0;
        end else begin
          filt_reg <= sync_reg[SYNC_STAGES-1];
        end
      end
`endif

      assign filt[gi]    = filt_reg;
      assign rise_en[gi] = mode[2*gi];
      assign fall_en[gi] = mode[2*gi+1];
    end
  endgenerate

  // filt_d tracks filt independent of mode, so enabling a channel later never
  // produces an edge from stale history.
  assign new_p = filt & ~filt_d_reg & rise_en;
  assign new_n = ~filt & filt_d_reg & fall_en;

  logic [POP_W-1:0] pop;
  logic [WIDTH-1:0] evt;

  always_comb begin
    evt = new_p | new_n;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(evt[i]);
    end
  end

  logic [SUM_W-1:0] cnt_base;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  // A counter clear restarts from this cycle's events so none are dropped.
  always_comb begin
    cnt_base = cnt_clr ? '0 : SUM_W'(evt_cnt);
    cnt_sum  = cnt_base + SUM_W'(pop);
    cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_d_reg <= '0;
      p_edge     <= '0;
      n_edge     <= '0;
      evt_sticky <= '0;
      evt_cnt    <= '0;
    end else begin
      filt_d_reg <= filt;
      p_edge     <= new_p;
      n_edge     <= new_n;
      // Setting takes priority over a simultaneous clear.
      evt_sticky <= (evt_sticky & ~clr) | new_p | new_n;
      evt_cnt    <= cnt_next;
    end
  end

  assign irq = |evt_sticky;

endmodule
